// File: rtl/clip_pkg.sv
// Shared types for the clip sequencer: queue entry layout, FSM states and
// the plane-selection helper. Coordinates are signed 12.12 in COORD_W bits.
package clip_pkg;

    localparam int unsigned NUM_PLANES = 6;
    localparam int unsigned COORD_W    = 24;
    localparam logic [2:0]  TAG_DONE   = 3'd6;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CLIP_REQ,
        RELEASE,
        PUSH0,
        PUSH1,
        EMIT
    } clip_seq_state_t;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic signed [COORD_W-1:0] z;
        logic signed [COORD_W-1:0] w;
    } vertex_t;

    typedef struct packed {
        vertex_t v0;
        vertex_t v1;
        vertex_t v2;
    } tri_t;

    typedef struct packed {
        tri_t       tri_v;
        logic [2:0] tag;
    } clip_entry_t;

    // Lowest enabled plane with index >= tag; returns NUM_PLANES when none.
    function automatic logic [2:0] next_plane(input logic [NUM_PLANES-1:0] en,
                                               input logic [2:0]            tag);
        logic [2:0] p;
        p = 3'(NUM_PLANES);
        for (int unsigned i = NUM_PLANES; i > 0; i--) begin
            if (en[i-1] && ((i - 1) >= 32'(tag))) begin
                p = 3'(i - 1);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/clip_sequencer_fifo.sv
// Work queue of partial triangles, each tagged with the next plane to test.
// last_pending_o is high when every stored entry has already passed all planes.
module clip_tri_fifo
    import clip_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned EW = $bits(clip_entry_t),
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          push_i,
    input  logic [EW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [EW-1:0] head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          last_pending_o
);

    clip_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] live_q;
    clip_entry_t   in_e;
    clip_entry_t   head_e;
    logic          do_push;
    logic          do_pop;
    logic          push_live;
    logic          pop_live;

    assign in_e    = clip_entry_t'(push_data_i);
    assign head_e  = mem_q[rd_q];
    assign head_o  = head_e;
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

    assign do_pop    = pop_i && !empty_o;
    assign do_push   = push_i && (!full_o || do_pop);
    assign push_live = do_push && (in_e.tag != TAG_DONE);
    assign pop_live  = do_pop && (head_e.tag != TAG_DONE);

    // Counting live (not yet finished) entries avoids scanning every slot.
    assign last_pending_o = (live_q == '0);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            live_q  <= '0;
        end else begin
            if (do_push) begin
                wr_q <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
            live_q  <= live_q + CW'(push_live) - CW'(pop_live);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= in_e;
        end
    end

endmodule

// File: rtl/clip_sequencer.sv
// Drives a single-plane clipper over up to six frustum planes, re-queueing
// split results breadth-first and streaming survivors downstream. WIDTH must equal COORD_W.
module clip_sequencer
    import clip_pkg::*;
#(
    parameter int unsigned WIDTH = COORD_W,
    parameter int unsigned DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  cfg_we_i,
    input  logic [2:0]            cfg_idx_i,
    input  logic [4*WIDTH-1:0]    cfg_plane_i,
    input  logic [5:0]            cfg_en_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [12*WIDTH-1:0]   in_tri_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [12*WIDTH-1:0]   out_tri_o,
    output logic                  out_last_o,
    output logic                  prim_done_o,
    output logic [3:0]            prim_tri_count_o,
    output logic                  busy_o,
    output logic                  overflow_o,
    output logic                  clip_start_o,
    input  logic                  clip_done_i,
    output logic [12*WIDTH-1:0]   clip_tri_o,
    output logic [4*WIDTH-1:0]    clip_plane_o,
    input  logic                  clip_valid_i,
    input  logic [1:0]            clip_num_i,
    input  logic [24*WIDTH-1:0]   clip_res_i
);

    localparam int unsigned TW = 12 * WIDTH;
    localparam int unsigned PW = 4 * WIDTH;
    localparam int unsigned RW = 24 * WIDTH;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    clip_seq_state_t         state_q, state_d;
    tri_t                    tri_q, tri_d;
    logic [PW-1:0]           plane_q, plane_d;
    logic [2:0]              tag_q, tag_d;
    logic [RW-1:0]           res_q, res_d;
    logic [1:0]              num_q, num_d;
    logic                    cv_q, cv_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    ovf_q;
    logic [PW-1:0]           planes_q [NUM_PLANES];
    logic [NUM_PLANES-1:0]   en_q;

    clip_entry_t             push_entry;
    clip_entry_t             head;
    logic                    push;
    logic                    pop;
    logic [CW-1:0]           fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_last;
    logic [2:0]              sel_plane;

    clip_tri_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .push_i         (push),
        .push_data_i    (push_entry),
        .pop_i          (pop),
        .head_o         (head),
        .count_o        (fifo_count),
        .full_o         (fifo_full),
        .empty_o        (fifo_empty),
        .last_pending_o (fifo_last)
    );

    assign sel_plane = next_plane(en_q, head.tag);

    always_comb begin
        state_d      = state_q;
        tri_d        = tri_q;
        plane_d      = plane_q;
        tag_d        = tag_q;
        res_d        = res_q;
        num_d        = num_q;
        cv_d         = cv_q;
        cnt_d        = cnt_q;
        push         = 1'b0;
        pop          = 1'b0;
        push_entry   = '0;
        in_ready_o   = 1'b0;
        out_valid_o  = 1'b0;
        clip_start_o = 1'b0;
        prim_done_o  = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    push             = 1'b1;
                    push_entry.tri_v = tri_t'(in_tri_i);
                    push_entry.tag   = '0;
                    cnt_d            = '0;
                    state_d          = FETCH;
                end
            end
            FETCH: begin
                if (fifo_empty) begin
                    prim_done_o = 1'b1;
                    state_d     = IDLE;
                end else begin
                    pop   = 1'b1;
                    tri_d = head.tri_v;
                    if (sel_plane == 3'(NUM_PLANES)) begin
                        state_d = EMIT;
                    end else begin
                        plane_d = planes_q[sel_plane];
                        tag_d   = sel_plane + 3'd1;
                        state_d = CLIP_REQ;
                    end
                end
            end
            CLIP_REQ: begin
                clip_start_o = 1'b1;
                if (clip_done_i) begin
                    res_d   = clip_res_i;
                    num_d   = clip_num_i;
                    cv_d    = clip_valid_i;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!clip_done_i) begin
                    state_d = (!cv_q || (num_q == 2'd0)) ? FETCH : PUSH0;
                end
            end
            PUSH0: begin
                push             = 1'b1;
                push_entry.tri_v = tri_t'(res_q[RW-1 -: TW]);
                push_entry.tag   = tag_q;
                state_d          = (num_q == 2'd2) ? PUSH1 : FETCH;
            end
            PUSH1: begin
                push             = 1'b1;
                push_entry.tri_v = tri_t'(res_q[TW-1:0]);
                push_entry.tag   = tag_q;
                state_d          = FETCH;
            end
            EMIT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    cnt_d   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            tri_q   <= '0;
            plane_q <= '0;
            tag_q   <= '0;
            res_q   <= '0;
            num_q   <= '0;
            cv_q    <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tri_q   <= tri_d;
            plane_q <= plane_d;
            tag_q   <= tag_d;
            res_q   <= res_d;
            num_q   <= num_d;
            cv_q    <= cv_d;
            cnt_q   <= cnt_d;
            if (push && fifo_full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Configuration is accepted only in IDLE so planes never change mid-primitive.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < NUM_PLANES; i++) begin
                planes_q[i] <= '0;
            end
            en_q <= '0;
        end else if (cfg_we_i && (state_q == IDLE)) begin
            en_q <= cfg_en_i;
            if (cfg_idx_i < 3'(NUM_PLANES)) begin
                planes_q[cfg_idx_i] <= cfg_plane_i;
            end
        end
    end

    assign busy_o           = (state_q != IDLE);
    assign overflow_o       = ovf_q;
    assign out_tri_o        = tri_q;
    assign clip_tri_o       = tri_q;
    assign clip_plane_o     = plane_q;
    assign out_last_o       = (state_q == EMIT) && ((fifo_count == '0) || fifo_last);
    assign prim_tri_count_o = prim_done_o ? cnt_q : '0;

endmodule

// File: tb/tb_clip_sequencer.sv
// Scoreboard bench for clip_sequencer with a behavioural clipper that XORs
// the input triangle with fixed keys to produce its two result triangles.
module tb_clip_sequencer;

    localparam int W  = 24;
    localparam int TW = 12 * W;
    localparam int PW = 4 * W;

    logic            clk = 1'b0;
    logic            reset_i = 1'b1;
    logic            cfg_we = 1'b0;
    logic [2:0]      cfg_idx = '0;
    logic [PW-1:0]   cfg_plane = '0;
    logic [5:0]      cfg_en = '0;
    logic            in_valid = 1'b0;
    logic            in_ready_o;
    logic [TW-1:0]   in_tri = '0;
    logic            out_valid_o;
    logic            out_ready = 1'b1;
    logic [TW-1:0]   out_tri_o;
    logic            out_last_o;
    logic            prim_done_o;
    logic [3:0]      prim_tri_count_o;
    logic            busy_o;
    logic            overflow_o;
    logic            clip_start_o;
    logic            clip_done = 1'b0;
    logic [TW-1:0]   clip_tri_o;
    logic [PW-1:0]   clip_plane_o;
    logic            clip_valid = 1'b0;
    logic [1:0]      clip_num = '0;
    logic [2*TW-1:0] clip_res = '0;

    clip_sequencer #(
        .WIDTH (W),
        .DEPTH (8)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .cfg_we_i         (cfg_we),
        .cfg_idx_i        (cfg_idx),
        .cfg_plane_i      (cfg_plane),
        .cfg_en_i         (cfg_en),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready_o),
        .in_tri_i         (in_tri),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready),
        .out_tri_o        (out_tri_o),
        .out_last_o       (out_last_o),
        .prim_done_o      (prim_done_o),
        .prim_tri_count_o (prim_tri_count_o),
        .busy_o           (busy_o),
        .overflow_o       (overflow_o),
        .clip_start_o     (clip_start_o),
        .clip_done_i      (clip_done),
        .clip_tri_o       (clip_tri_o),
        .clip_plane_o     (clip_plane_o),
        .clip_valid_i     (clip_valid),
        .clip_num_i       (clip_num),
        .clip_res_i       (clip_res)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [TW-1:0] t;
        logic          last;
        int            cyc;
    } out_exp_t;

    typedef struct {
        int cnt;
        int cyc;
    } prim_exp_t;

    out_exp_t  exp_q[$];
    prim_exp_t prim_q[$];

    logic [TW-1:0] K1;
    logic [TW-1:0] K2;

    logic          mdl_valid = 1'b1;
    logic [1:0]    mdl_num = 2'd2;
    logic          mdl_hold = 1'b0;
    int            starts = 0;
    logic [PW-1:0] last_plane = '0;
    logic [TW-1:0] last_tri = '0;

    task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [TW-1:0] mk_tri(input logic [23:0] base);
        logic [TW-1:0] t;
        t = '0;
        for (int c = 0; c < 12; c++) begin
            t[(11 - c) * 24 +: 24] = base + 24'(c * 273);
        end
        return t;
    endfunction

    function automatic logic [PW-1:0] mk_plane(input int i);
        return {24'h100000 + 24'(i), 24'h200000 + 24'(i), 24'h300000 + 24'(i), 24'h400000 + 24'(i)};
    endfunction

    task automatic cfg_write(input int idx, input logic [PW-1:0] pl, input logic [5:0] en);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_idx   = 3'(idx);
        cfg_plane = pl;
        cfg_en    = en;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic send(input logic [TW-1:0] t, output int hs);
        @(negedge clk);
        in_valid = 1'b1;
        in_tri   = t;
        for (int k = 0; k < 500; k++) begin
            if (in_ready_o) break;
            @(negedge clk);
        end
        chk("send_ready", in_ready_o, 1);
        @(posedge clk);
        #1;
        hs       = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_prims(input string nm);
        for (int k = 0; k < 3000; k++) begin
            if (prim_q.size() == 0 && in_ready_o) break;
            @(negedge clk);
        end
        chk(nm, prim_q.size(), 0);
    endtask

    // Behavioural clipper: fixed latency, done held until start drops.
    initial begin : clipper_model
        int   mcnt;
        logic seen;
        mcnt = 0;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!clip_start_o) begin
                clip_done = 1'b0;
                mcnt      = 0;
                seen      = 1'b0;
            end else if (!clip_done) begin
                if (!seen) begin
                    seen       = 1'b1;
                    starts++;
                    last_plane = clip_plane_o;
                    last_tri   = clip_tri_o;
                end
                if (!mdl_hold) begin
                    if (mcnt == 2) begin
                        clip_done  = 1'b1;
                        clip_valid = mdl_valid;
                        clip_num   = mdl_num;
                        clip_res   = {clip_tri_o ^ K1, clip_tri_o ^ K2};
                    end else begin
                        mcnt++;
                    end
                end
            end
        end
    end

    initial begin : monitor
        logic          pend;
        int            vstart;
        logic [TW-1:0] held;
        out_exp_t      e;
        prim_exp_t     pe;
        pend   = 1'b0;
        vstart = 0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                pend = 1'b0;
            end else begin
                if (out_valid_o) begin
                    if (!pend) begin
                        pend   = 1'b1;
                        vstart = cyc;
                        held   = out_tri_o;
                    end else begin
                        chk("out_hold", out_tri_o, held);
                    end
                    if (out_ready) begin
                        pend = 1'b0;
                        if (exp_q.size() == 0) begin
                            chk("out_unexpected", out_valid_o, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("out_tri", out_tri_o, e.t);
                            chk("out_last", out_last_o, e.last);
                            if (e.cyc >= 0) chk("out_latency", vstart, e.cyc);
                        end
                    end
                end else begin
                    pend = 1'b0;
                end
                if (prim_done_o) begin
                    if (prim_q.size() == 0) begin
                        chk("prim_unexpected", prim_done_o, 0);
                    end else begin
                        pe = prim_q.pop_front();
                        chk("prim_count", prim_tri_count_o, pe.cnt);
                        if (pe.cyc >= 0) chk("prim_latency", cyc, pe.cyc);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int            hs;
        int            s0;
        logic [TW-1:0] t;
        logic [TW-1:0] x;
        logic [TW-1:0] snap;

        K1 = mk_tri(24'h0F0F01);
        K2 = mk_tri(24'h00F0F2);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_overflow", overflow_o, 0);
        chk("rst_clip_start", clip_start_o, 0);
        chk("rst_prim_done", prim_done_o, 0);
        chk("rst_out_tri", out_tri_o, 0);
        chk("rst_out_last", out_last_o, 0);
        reset_i = 1'b0;

        for (int i = 0; i < 6; i++) cfg_write(i, mk_plane(i), 6'b000000);

        // Pass-through with exact latency
        s0 = starts;
        t  = mk_tri(24'h000100);
        send(t, hs);
        exp_q.push_back('{t, 1'b1, hs + 1});
        prim_q.push_back('{1, hs + 2});
        wait_prims("pt_done");
        chk("pt_no_clip", starts - s0, 0);

        // Single split on plane 0
        cfg_write(0, mk_plane(0), 6'b000001);
        mdl_valid = 1'b1;
        mdl_num   = 2'd2;
        s0 = starts;
        t  = mk_tri(24'h012345);
        send(t, hs);
        exp_q.push_back('{t ^ K1, 1'b0, -1});
        exp_q.push_back('{t ^ K2, 1'b1, -1});
        prim_q.push_back('{2, -1});
        wait_prims("split_done");
        chk("split_starts", starts - s0, 1);
        chk("split_plane", last_plane, mk_plane(0));
        chk("split_tri", last_tri, t);

        // Cull on plane 3
        cfg_write(3, mk_plane(3), 6'b001000);
        mdl_valid = 1'b0;
        s0 = starts;
        t  = mk_tri(24'h0A0B0C);
        send(t, hs);
        prim_q.push_back('{0, -1});
        wait_prims("cull_done");
        chk("cull_starts", starts - s0, 1);
        chk("cull_plane", last_plane, mk_plane(3));
        chk("cull_no_overflow", overflow_o, 0);

        // Overflow: planes 0-3, always split; only first result of each level-3 clip fits
        cfg_write(0, mk_plane(0), 6'b001111);
        mdl_valid = 1'b1;
        mdl_num   = 2'd2;
        s0 = starts;
        t  = mk_tri(24'h055500);
        send(t, hs);
        for (int i = 0; i < 8; i++) begin
            x = t;
            for (int b = 2; b >= 0; b--) x = x ^ (i[b] ? K2 : K1);
            x = x ^ K1;
            exp_q.push_back('{x, (i == 7), -1});
        end
        prim_q.push_back('{8, -1});
        wait_prims("ovf_done");
        chk("ovf_flag", overflow_o, 1);
        chk("ovf_starts", starts - s0, 15);
        chk("ovf_idle", busy_o, 0);

        // Backpressure and configuration lockout
        cfg_write(0, mk_plane(0), 6'b000000);
        out_ready = 1'b0;
        t = mk_tri(24'h0C0FFE);
        send(t, hs);
        exp_q.push_back('{t, 1'b1, hs + 1});
        prim_q.push_back('{1, -1});
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (out_valid_o) break;
        end
        snap = out_tri_o;
        cfg_write(0, {4{24'hDEAD00}}, 6'b000001);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", out_valid_o, 1);
            chk("bp_stable", out_tri_o, snap);
            chk("bp_tri", out_tri_o, t);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_prims("bp_done");
        s0 = starts;
        t  = mk_tri(24'h077700);
        send(t, hs);
        exp_q.push_back('{t, 1'b1, hs + 1});
        prim_q.push_back('{1, hs + 2});
        wait_prims("lock_done");
        chk("lock_no_clip", starts - s0, 0);

        // Reset while the clipper request is outstanding
        cfg_write(0, mk_plane(0), 6'b000001);
        mdl_hold = 1'b1;
        t = mk_tri(24'h0ABC00);
        send(t, hs);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (clip_start_o) break;
        end
        chk("rr_start_seen", clip_start_o, 1);
        #1 reset_i = 1'b1;
        #1;
        chk("rr_start_low", clip_start_o, 0);
        chk("rr_busy_low", busy_o, 0);
        @(posedge clk);
        #1 reset_i = 1'b0;
        mdl_hold = 1'b0;
        chk("rr_in_ready", in_ready_o, 1);
        chk("rr_out_valid", out_valid_o, 0);
        s0 = starts;
        t  = mk_tri(24'h033300);
        send(t, hs);
        exp_q.push_back('{t, 1'b1, hs + 1});
        prim_q.push_back('{1, hs + 2});
        wait_prims("rr_done");
        chk("rr_no_clip", starts - s0, 0);

        repeat (5) @(negedge clk);
        chk("sb_out_drained", exp_q.size(), 0);
        chk("sb_prim_drained", prim_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
